// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data memory and the core's load/store decode.
// Holds the access-size encodings, the memory controller state encoding and the
// lane merge / load extension helpers used by data_mem_be.
package mem_pkg;

  // Access size encodings, shared with the core pipeline's load/store decode.
  localparam logic [1:0] SZ_BYTE    = 2'd0;
  localparam logic [1:0] SZ_HALF    = 2'd1;
  localparam logic [1:0] SZ_WORD    = 2'd2;
  localparam logic [1:0] SZ_ILLEGAL = 2'd3;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } mem_state_e;

  // Merge right-justified store data into the addressed lane(s) of an existing word.
  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] w;
    w = old_word;
    case (size)
      SZ_BYTE: w[{lane, 3'b000} +: 8]     = wdata[7:0];
      SZ_HALF: w[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: w = wdata;
    endcase
    return w;
  endfunction

  // Pick the addressed lane(s) of a word and sign- or zero-extend to 32 bits.
  function automatic logic [31:0] load_ext(input logic [31:0] word,
                                           input logic [1:0]  size,
                                           input logic [1:0]  lane,
                                           input logic        is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: r = is_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = is_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_rsp_pipe.sv
// LATENCY-deep shift register carrying {valid, err, rdata} for the data memory
// response path. An asynchronous clear drops every in-flight response at once.
//   clk_i    clock
//   rst_ni   asynchronous active-low clear of all stages
//   valid_i  / err_i / rdata_i   stage-0 input, captured every rising edge
//   valid_o  / err_o / rdata_o   last stage output
module mem_rsp_pipe #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic              err_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              valid_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] err_q;
  logic [DATA_W-1:0]  rdata_q [LATENCY];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        rdata_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      err_q[0]   <= err_i;
      rdata_q[0] <= rdata_i;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= err_q[i-1];
        rdata_q[i] <= rdata_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[LATENCY-1];
  assign err_o   = err_q[LATENCY-1];
  assign rdata_o = rdata_q[LATENCY-1];

endmodule

// File: rtl/data_mem_be.sv
// Pipelined byte-enable data memory for the MEM stage of the five-stage MIPS core.
// Byte/half/word stores merge into the addressed word; loads are sign- or
// zero-extended. One request per cycle, fixed LATENCY response. After reset a
// sweep zeroes all DEPTH words before requests are accepted.
//   clk           clock
//   reset         asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready only in RUN)
//   req_we, req_size, req_unsigned, req_addr, req_wdata, req_pc   request fields
//   rsp_valid, rsp_rdata, rsp_err   response, LATENCY cycles after acceptance
//   busy          high while the clear sweep runs
module data_mem_be #(
  parameter int unsigned ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 1,   // legal 1..4
  parameter int unsigned TRACE     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  import mem_pkg::*;

  localparam int unsigned DEPTH = 1 << ADDR_W;
  // Array size in bytes; 33 bits so ADDR_W up to 30 does not overflow.
  localparam logic [32:0] LIM_BYTES = 33'd1 << (ADDR_W + 2);

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [31:0]       mem_q [DEPTH];

  logic [31:0]       off;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  logic              out_of_range;
  logic              err;
  logic              accept;
  logic              st_en;
  logic [31:0]       rd_word;
  logic [31:0]       merged;
  logic [31:0]       ld_data;

  // ---------------------------------------------------------------------------
  // Controller FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (&cnt_q) state_d = ST_RUN;  // last word cleared this edge
      end
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      ST_CLEAR: begin
        req_ready = 1'b0;
        busy      = 1'b1;
      end
      ST_RUN: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  always_comb begin
    off          = req_addr - BASE_ADDR;
    idx          = off[ADDR_W+1:2];
    lane         = off[1:0];
    out_of_range = ({1'b0, off} >= LIM_BYTES);
    unique case (req_size)
      SZ_BYTE: err = out_of_range;
      SZ_HALF: err = out_of_range | off[0];
      SZ_WORD: err = out_of_range | (off[1:0] != 2'b00);
      default: err = 1'b1;
    endcase
  end

  assign accept  = req_valid & req_ready;
  assign st_en   = accept & req_we & ~err;
  // Read sees every store committed on an earlier edge.
  assign rd_word = mem_q[idx];
  assign merged  = store_merge(rd_word, req_wdata, req_size, lane);
  assign ld_data = (accept && !req_we && !err) ?
                   load_ext(rd_word, req_size, lane, req_unsigned) : 32'h0;

  // ---------------------------------------------------------------------------
  // Storage: clear sweep owns the write port until RUN
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem_q[cnt_q] <= 32'h0;
    end else if (st_en) begin
      mem_q[idx] <= merged;
    end
  end

  // ---------------------------------------------------------------------------
  // Response pipeline
  // ---------------------------------------------------------------------------
  mem_rsp_pipe #(
    .LATENCY (LATENCY),
    .DATA_W  (32)
  ) u_rsp_pipe (
    .clk_i   (clk),
    .rst_ni  (reset),
    .valid_i (accept),
    .err_i   (accept & err),
    .rdata_i (ld_data),
    .valid_o (rsp_valid),
    .err_o   (rsp_err),
    .rdata_o (rsp_rdata)
  );

  // ---------------------------------------------------------------------------
  // Store trace (simulation only)
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  if (TRACE != 0) begin : g_trace
    logic [31:0] trace_addr;
    assign trace_addr = BASE_ADDR + {{(30-ADDR_W){1'b0}}, idx, 2'b00};
    always @(posedge clk) begin
      if (reset && st_en) begin
        $display("%d@%h: *%h <= %h", $time, req_pc, trace_addr, merged);
      end
    end
  end
`endif

endmodule
